// File: rtl/if_pkg.sv
// Shared widths and the {pc, instr} entry type used by the fetch/decode instruction buffer.
package if_pkg;

  localparam int PC_W    = 30;
  localparam int INSTR_W = 32;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } if_entry_t;

endpackage

// File: rtl/ifbuf_fifo.sv
// In-order entry storage for the fetch/decode buffer: head/tail pointers wrapping modulo DEPTH,
// occupancy count, and push/pop/clear controls qualified by the parent.
module ifbuf_fifo
  import if_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic          clear,
  input  if_entry_t     wr_data,
  output if_entry_t     rd_data,
  output logic [CW-1:0] count,
  output logic [CW-1:0] count_next
);

  if_entry_t     mem [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // count_next is exported so the parent can compute credit for the coming cycle
  always_comb begin
    count_next = count;
    if (clear)
      count_next = '0;
    else if (push && !pop)
      count_next = count + CW'(1);
    else if (pop && !push)
      count_next = count - CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      count <= count_next;
      if (clear) begin
        head <= '0;
        tail <= '0;
      end else begin
        if (push) tail <= wrap_inc(tail);
        if (pop)  head <= wrap_inc(head);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push && !clear) begin
      mem[tail] <= wr_data;
    end
  end

  assign rd_data = mem[head];

  // The parent's credit scheme must make a push into a full queue impossible.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && (count == CW'(DEPTH))));

endmodule

// File: rtl/fetch_decode_buffer.sv
// Instruction buffer between fetch and decode with registered credit back-pressure and jump flush.
// Optional perf counters (stall_cnt, flush_cnt) are built when IFBUF_PERF_CNT_EN is defined.
module fetch_decode_buffer
  import if_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               async_rst_n,
  input  logic               fetch_rst,
  input  logic               flush,
  input  logic [PC_W-1:0]    pc_in,
  input  logic [INSTR_W-1:0] instr_in,
  output logic               fetch_en,
  output logic               id_valid,
  input  logic               id_ready,
  output logic [PC_W-1:0]    id_pc,
  output logic [INSTR_W-1:0] id_instr
`ifdef IFBUF_PERF_CNT_EN
  ,
  output logic [31:0]        stall_cnt,
  output logic [31:0]        flush_cnt
`endif
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = CW + 1;

  logic          in_vld;
  logic          in_vld_next;
  logic          push;
  logic          pop;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic [SW-1:0] credit_need;
  if_entry_t     wr_entry;
  if_entry_t     head_entry;

  // A pair is fresh only if fetch actually advanced last cycle; a held fetch rereads the same word.
  assign in_vld_next = (fetch_en | flush) & ~fetch_rst;

  // Handshake: decode consumes the head on any cycle with id_valid & id_ready; a flush in the
  // same cycle overrides both the pop and the capture of that cycle's word.
  assign push = in_vld & ~flush;
  assign pop  = id_valid & id_ready & ~flush;

  assign credit_need = SW'(count_next) + SW'(in_vld_next);
  assign wr_entry    = '{pc: pc_in, instr: instr_in};

  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      in_vld   <= 1'b0;
      fetch_en <= 1'b1;
    end else begin
      in_vld   <= in_vld_next;
      fetch_en <= (credit_need < SW'(DEPTH));
    end
  end

  ifbuf_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (async_rst_n),
    .push       (push),
    .pop        (pop),
    .clear      (flush),
    .wr_data    (wr_entry),
    .rd_data    (head_entry),
    .count      (count),
    .count_next (count_next)
  );

  assign id_valid = (count != '0);
  assign id_pc    = head_entry.pc;
  assign id_instr = head_entry.instr;

`ifdef IFBUF_PERF_CNT_EN
  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!fetch_en) stall_cnt <= stall_cnt + 32'd1;
      if (flush)     flush_cnt <= flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_decode_buffer.sv
// Bench for fetch_decode_buffer: fetch-stage/imem environment, queue-based reference model,
// program-order stream scoreboard, a cycle table for boot/back-pressure/flush, and random traffic.
module tb_fetch_decode_buffer;

  localparam int DEPTH = 4;

  logic        clk;
  logic        async_rst_n;
  logic        fetch_rst;
  logic        flush;
  logic [29:0] pc_in;
  logic [31:0] instr_in;
  logic        fetch_en;
  logic        id_valid;
  logic        id_ready;
  logic [29:0] id_pc;
  logic [31:0] id_instr;
`ifdef IFBUF_PERF_CNT_EN
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;
  int unsigned stall_ref;
  int unsigned flush_ref;
`endif

  fetch_decode_buffer #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .async_rst_n (async_rst_n),
    .fetch_rst   (fetch_rst),
    .flush       (flush),
    .pc_in       (pc_in),
    .instr_in    (instr_in),
    .fetch_en    (fetch_en),
    .id_valid    (id_valid),
    .id_ready    (id_ready),
    .id_pc       (id_pc),
    .id_instr    (id_instr)
`ifdef IFBUF_PERF_CNT_EN
    ,
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt)
`endif
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  // reference model state: queued {pc, instr}, capture qualifier and credit output
  logic [61:0] exp_q[$];
  logic        m_in_vld;
  logic        m_fetch_en;
  logic [29:0] e_addr;
  logic [29:0] target;
  logic [29:0] next_exp_pc;
  int          n_cmp;
  int          n_bad;

  typedef struct {
    logic        frst;
    logic        fl;
    logic        rdy;
    logic        ev;
    logic        ef;
    logic [29:0] epc;
  } vec_t;
  vec_t tbl[$];

  function automatic logic [31:0] instr_of(input logic [29:0] pc);
    return {2'b00, pc} ^ 32'hA5A5_A5A5;
  endfunction

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic void add(input logic frst, input logic fl, input logic rdy,
                              input logic ev, input logic ef, input logic [29:0] epc);
    vec_t v;
    v.frst = frst; v.fl = fl; v.rdy = rdy; v.ev = ev; v.ef = ef; v.epc = epc;
    tbl.push_back(v);
  endfunction

  // Called at the negative edge: DUT outputs against model, and consumed words against program order.
  function automatic void check_model();
    chk("id_valid", 32'(id_valid), 32'(exp_q.size() != 0));
    chk("fetch_en", 32'(fetch_en), 32'(m_fetch_en));
    if (exp_q.size() != 0) begin
      chk("id_pc", 32'(id_pc), 32'(exp_q[0][61:32]));
      chk("id_instr", id_instr, exp_q[0][31:0]);
      if (id_ready && !flush) begin
        chk("stream_pc", 32'(id_pc), 32'(next_exp_pc));
        chk("stream_instr", id_instr, instr_of(next_exp_pc));
        next_exp_pc = next_exp_pc + 30'd1;
      end
    end
    if (flush) next_exp_pc = target;
`ifdef IFBUF_PERF_CNT_EN
    chk("stall_cnt", stall_cnt, stall_ref);
    chk("flush_cnt", flush_cnt, flush_ref);
`endif
  endfunction

  // Driver: from negedge, step the fetch/imem environment and the model across the next posedge.
  task automatic advance();
    logic        en, frst, fl, mpush, mpop, nv;
    logic [29:0] ta, cap_pc;
    logic [31:0] cap_in;
    en     = fetch_en | flush;
    frst   = fetch_rst;
    fl     = flush;
    ta     = flush ? target : e_addr;
    cap_pc = pc_in;
    cap_in = instr_in;
    mpush  = m_in_vld && !fl;
    mpop   = (exp_q.size() != 0) && id_ready && !fl;
`ifdef IFBUF_PERF_CNT_EN
    if (!m_fetch_en) stall_ref++;
    if (fl) flush_ref++;
`endif
    @(posedge clk);
    #1;
    if (frst) begin
      e_addr = '0;
    end else if (en) begin
      pc_in    = ta;
      instr_in = instr_of(ta);
      e_addr   = ta + 30'd1;
    end
    if (fl) begin
      exp_q.delete();
    end else begin
      if (mpop) void'(exp_q.pop_front());
      if (mpush) exp_q.push_back({cap_pc, cap_in});
    end
    nv         = (m_fetch_en | fl) & ~frst;
    m_in_vld   = nv;
    m_fetch_en = (exp_q.size() + int'(nv)) < DEPTH;
  endtask

  task automatic tick();
    @(negedge clk);
    check_model();
    advance();
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must collapse before any clock edge.
  task automatic do_reset();
    @(negedge clk);
    #2;
    async_rst_n = 1'b0;
    fetch_rst   = 1'b1;
    flush       = 1'b0;
    #1;
    chk("rst_id_valid", 32'(id_valid), 32'd0);
    chk("rst_fetch_en", 32'(fetch_en), 32'd1);
    chk("rst_id_pc", 32'(id_pc), 32'd0);
    chk("rst_id_instr", id_instr, 32'd0);
`ifdef IFBUF_PERF_CNT_EN
    chk("rst_stall_cnt", stall_cnt, 32'd0);
    chk("rst_flush_cnt", flush_cnt, 32'd0);
    stall_ref = 0;
    flush_ref = 0;
`endif
    exp_q.delete();
    m_in_vld    = 1'b0;
    m_fetch_en  = 1'b1;
    e_addr      = '0;
    pc_in       = '0;
    instr_in    = '0;
    next_exp_pc = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    async_rst_n = 1'b1;
  endtask

  initial begin
    n_cmp       = 0;
    n_bad       = 0;
    async_rst_n = 1'b0;
    fetch_rst   = 1'b1;
    flush       = 1'b0;
    id_ready    = 1'b1;
    target      = 30'h100;
    pc_in       = '0;
    instr_in    = '0;

    // boot, 12 cycles of back-pressure, then flush to 0x100 with three entries queued and id_ready=1
    add(1, 0, 1, 0, 1, 30'd0);
    add(1, 0, 1, 0, 1, 30'd0);
    add(0, 0, 1, 0, 1, 30'd0);
    add(0, 0, 1, 0, 1, 30'd0);
    add(0, 0, 1, 1, 1, 30'd0);
    add(0, 0, 1, 1, 1, 30'd1);
    add(0, 0, 1, 1, 1, 30'd2);
    add(0, 0, 0, 1, 1, 30'd3);
    add(0, 0, 0, 1, 1, 30'd3);
    for (int k = 0; k < 10; k++) add(0, 0, 0, 1, 0, 30'd3);
    add(0, 0, 1, 1, 0, 30'd3);
    add(0, 0, 1, 1, 1, 30'd4);
    add(0, 0, 1, 1, 1, 30'd5);
    add(0, 0, 1, 1, 1, 30'd6);
    add(0, 0, 0, 1, 1, 30'd7);
    add(0, 1, 1, 1, 0, 30'd7);
    add(0, 0, 1, 0, 1, 30'd0);
    add(0, 0, 1, 1, 1, 30'h100);
    add(0, 0, 1, 1, 1, 30'h101);

    do_reset();
    foreach (tbl[i]) begin
      fetch_rst = tbl[i].frst;
      flush     = tbl[i].fl;
      id_ready  = tbl[i].rdy;
      target    = 30'h100;
      @(negedge clk);
      check_model();
      chk($sformatf("tbl%0d_valid", i), 32'(id_valid), 32'(tbl[i].ev));
      chk($sformatf("tbl%0d_fetch_en", i), 32'(fetch_en), 32'(tbl[i].ef));
      if (tbl[i].ev) begin
        chk($sformatf("tbl%0d_pc", i), 32'(id_pc), 32'(tbl[i].epc));
        chk($sformatf("tbl%0d_instr", i), id_instr, instr_of(tbl[i].epc));
      end
      advance();
    end

    // random traffic: bursty decode stalls and occasional jumps to random targets
    for (int k = 0; k < 600; k++) begin
      fetch_rst = 1'b0;
      flush     = ($urandom_range(0, 15) == 0);
      target    = 30'($urandom_range(0, 32'h3FFF_FFFF));
      id_ready  = ($urandom_range(0, 9) < 6);
      tick();
    end

    // fill the queue, then pulse async reset and check the stream restarts from PC 0
    flush    = 1'b0;
    id_ready = 1'b0;
    for (int k = 0; k < 8; k++) tick();
    do_reset();
    for (int k = 0; k < 12; k++) begin
      fetch_rst = (k < 2);
      flush     = 1'b0;
      id_ready  = 1'b1;
      @(negedge clk);
      check_model();
      if (k == 3) chk("restart_valid_early", 32'(id_valid), 32'd0);
      if (k == 4) begin
        chk("restart_valid", 32'(id_valid), 32'd1);
        chk("restart_pc", 32'(id_pc), 32'd0);
      end
      advance();
    end

`ifdef IFBUF_PERF_CNT_EN
    do_reset();
    for (int k = 0; k < 20; k++) begin
      fetch_rst = (k < 2);
      flush     = (k == 16) || (k == 18);
      id_ready  = 1'b0;
      target    = 30'h200;
      @(negedge clk);
      check_model();
      if (k == 16) begin
        chk("perf_stall_10", stall_cnt, 32'd10);
        chk("perf_flush_0", flush_cnt, 32'd0);
      end
      if (k == 19) chk("perf_flush_2", flush_cnt, 32'd2);
      advance();
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
